// File: rtl/ysyx_25020047_idu_if.sv
// Handshake and write-back bundle between IFU, IDU, EXU and the write-back path.
// The slave modport is the IDU side; master is the environment driving it.
interface ysyx_25020047_idu_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_inst_type;
   logic [31:0] out_rdata1;
   logic [31:0] out_rdata2;
   logic [31:0] out_imm;
   logic [31:0] out_pc;
   logic [4:0]  out_rd;
   logic        wb_wen;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        halted;
   logic        illegal;

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready, wb_wen, wb_waddr, wb_wdata,
      output in_ready, out_valid, out_inst_type, out_rdata1, out_rdata2,
             out_imm, out_pc, out_rd, halted, illegal
   );

   modport master (
      output in_valid, in_inst, in_pc, out_ready, wb_wen, wb_waddr, wb_wdata,
      input  in_ready, out_valid, out_inst_type, out_rdata1, out_rdata2,
             out_imm, out_pc, out_rd, halted, illegal
   );
endinterface

// File: rtl/ysyx_25020047_idu.sv
// RV32I subset decode/issue stage: register file, busy scoreboard and a single
// output register towards the EXU.
module ysyx_25020047_idu (
   input logic                  clk,
   input logic                  rst,
   ysyx_25020047_idu_if.slave   bus
);
   logic [31:0] inst;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd, rd_eff;
   logic [31:0] imm_i, imm_s, imm_u, imm_j;

   assign inst   = bus.in_inst;
   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign rd     = inst[11:7];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   logic [8:0]  itype;
   logic [31:0] imm;
   logic        use_rs1, use_rs2, wr_rd;

   always_comb begin
      itype   = '0;
      imm     = '0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wr_rd   = 1'b0;
      if (inst == 32'h0010_0073) begin
         itype = 9'h004;
      end else begin
         case (opcode)
            7'b0010011: if (funct3 == 3'b000) begin
               itype = 9'h001; imm = imm_i; use_rs1 = 1'b1; wr_rd = 1'b1;
            end
            7'b1100111: if (funct3 == 3'b000) begin
               itype = 9'h002; imm = imm_i; use_rs1 = 1'b1; wr_rd = 1'b1;
            end
            7'b0110011: if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
               itype = 9'h008; use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1;
            end
            7'b0110111: begin itype = 9'h010; imm = imm_u; wr_rd = 1'b1; end
            7'b0010111: begin itype = 9'h020; imm = imm_u; wr_rd = 1'b1; end
            7'b1101111: begin itype = 9'h040; imm = imm_j; wr_rd = 1'b1; end
            7'b0100011: if (funct3 == 3'b010) begin
               itype = 9'h080; imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b0000011: if (funct3 == 3'b010) begin
               itype = 9'h100; imm = imm_i; use_rs1 = 1'b1; wr_rd = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rd_eff = wr_rd ? rd : 5'd0;

   logic [31:0] regs_q [32];
   logic [31:0] busy_q, busy_d, clr_mask, set_mask, busy_eff;
   logic        halted_q, halted_d, illegal_q, illegal_d;
   logic        out_valid_q;
   logic [8:0]  out_type_q;
   logic [31:0] out_rdata1_q, out_rdata2_q, out_imm_q, out_pc_q;
   logic [4:0]  out_rd_q;
   logic        hazard, in_ready, accept;
   logic [31:0] rdata1, rdata2;

   // Bit 0 of every mask stays 0 so x0 never reads as busy.
   always_comb begin
      clr_mask = '0;
      if (bus.wb_wen) clr_mask[bus.wb_waddr] = 1'b1;
      clr_mask[0] = 1'b0;
   end

   assign busy_eff = busy_q & ~clr_mask;
   assign hazard   = (use_rs1 && busy_eff[rs1]) || (use_rs2 && busy_eff[rs2]) || busy_eff[rd_eff];
   assign in_ready = !halted_q && !hazard && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      set_mask = '0;
      if (accept) set_mask[rd_eff] = 1'b1;
      set_mask[0] = 1'b0;
      busy_d    = busy_eff | set_mask;
      halted_d  = halted_q | (accept && itype == 9'h004);
      illegal_d = illegal_q | (accept && itype == 9'h000);
   end

   // Write-through: a read of the register being written this cycle sees the new data.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (rs1 != 5'd0) rdata1 = (bus.wb_wen && bus.wb_waddr == rs1) ? bus.wb_wdata : regs_q[rs1];
      if (rs2 != 5'd0) rdata2 = (bus.wb_wen && bus.wb_waddr == rs2) ? bus.wb_wdata : regs_q[rs2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
         busy_q       <= '0;
         halted_q     <= 1'b0;
         illegal_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_type_q   <= '0;
         out_rdata1_q <= '0;
         out_rdata2_q <= '0;
         out_imm_q    <= '0;
         out_pc_q     <= '0;
         out_rd_q     <= '0;
      end else begin
         busy_q    <= busy_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         if (bus.wb_wen && bus.wb_waddr != 5'd0) regs_q[bus.wb_waddr] <= bus.wb_wdata;
         if (accept) begin
            out_valid_q  <= 1'b1;
            out_type_q   <= itype;
            out_rdata1_q <= rdata1;
            out_rdata2_q <= rdata2;
            out_imm_q    <= imm;
            out_pc_q     <= bus.in_pc;
            out_rd_q     <= rd_eff;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_inst_type = out_type_q;
   assign bus.out_rdata1    = out_rdata1_q;
   assign bus.out_rdata2    = out_rdata2_q;
   assign bus.out_imm       = out_imm_q;
   assign bus.out_pc        = out_pc_q;
   assign bus.out_rd        = out_rd_q;
   assign bus.halted        = halted_q;
   assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_ysyx_25020047_idu.sv
// Directed bench for the decode/issue stage: hazards, bypass, hold, halt and reset.
module tb_ysyx_25020047_idu;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   ysyx_25020047_idu_if bus ();

   ysyx_25020047_idu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_inst   = 32'h0;
      bus.in_pc     = 32'h0;
      bus.out_ready = 1'b0;
      bus.wb_wen    = 1'b0;
      bus.wb_waddr  = 5'd0;
      bus.wb_wdata  = 32'h0;

      // asynchronous reset, checked before any clock edge
      #3 rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_halted",    {31'b0, bus.halted},    32'd0);
      chk("rst_illegal",   {31'b0, bus.illegal},   32'd0);
      chk("rst_type",      {23'b0, bus.out_inst_type}, 32'd0);
      chk("rst_rd",        {27'b0, bus.out_rd},    32'd0);
      chk("rst_imm",       bus.out_imm,            32'd0);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);

      // addi x1,x0,5
      bus.in_valid  = 1'b1;
      bus.in_inst   = 32'h0050_0093;
      bus.in_pc     = 32'h8000_0000;
      bus.out_ready = 1'b1;
      tick();
      chk("addi_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("addi_type",  {23'b0, bus.out_inst_type}, 32'h001);
      chk("addi_imm",   bus.out_imm, 32'd5);
      chk("addi_rd",    {27'b0, bus.out_rd}, 32'd1);
      chk("addi_rs1",   bus.out_rdata1, 32'd0);
      chk("addi_pc",    bus.out_pc, 32'h8000_0000);
      chk("busy1_set",  {31'b0, dut.busy_q[1]}, 32'd1);

      // add x2,x1,x1 stalls on busy x1
      bus.in_inst = 32'h0010_8133;
      bus.in_pc   = 32'h8000_0004;
      #1;
      chk("add_stall0", {31'b0, bus.in_ready}, 32'd0);
      tick();
      chk("add_bubble", {31'b0, bus.out_valid}, 32'd0);
      chk("add_stall1", {31'b0, bus.in_ready}, 32'd0);
      bus.wb_wen   = 1'b1;
      bus.wb_waddr = 5'd1;
      bus.wb_wdata = 32'd5;
      #1;
      chk("add_release", {31'b0, bus.in_ready}, 32'd1);
      tick();
      bus.wb_wen = 1'b0;
      chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("add_type",  {23'b0, bus.out_inst_type}, 32'h008);
      chk("add_rs1",   bus.out_rdata1, 32'd5);
      chk("add_rs2",   bus.out_rdata2, 32'd5);
      chk("add_rd",    {27'b0, bus.out_rd}, 32'd2);
      chk("busy1_clr", {31'b0, dut.busy_q[1]}, 32'd0);

      // lui x3,0x12345 then hold with out_ready low
      bus.in_inst = 32'h1234_51B7;
      bus.in_pc   = 32'h8000_0008;
      tick();
      bus.out_ready = 1'b0;
      bus.in_inst   = 32'h0070_0213;  // addi x4,x0,7 waits behind it
      bus.in_pc     = 32'h8000_000C;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lui_hold_ready", {31'b0, bus.in_ready}, 32'd0);
         chk("lui_hold_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("lui_type",       {23'b0, bus.out_inst_type}, 32'h010);
         chk("lui_imm",        bus.out_imm, 32'h1234_5000);
         chk("lui_rd",         {27'b0, bus.out_rd}, 32'd3);
         chk("lui_pc",         bus.out_pc, 32'h8000_0008);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("lui_release", {31'b0, bus.in_ready}, 32'd1);
      tick();
      chk("addi4_imm", bus.out_imm, 32'd7);
      chk("addi4_rd",  {27'b0, bus.out_rd}, 32'd4);

      // back-to-back independent addi x5..x7
      bus.in_inst = 32'h0010_0293; #1; chk("b2b_ready0", {31'b0, bus.in_ready}, 32'd1); tick();
      chk("b2b_imm0", bus.out_imm, 32'd1); chk("b2b_rd0", {27'b0, bus.out_rd}, 32'd5);
      bus.in_inst = 32'h0020_0313; #1; chk("b2b_ready1", {31'b0, bus.in_ready}, 32'd1); tick();
      chk("b2b_imm1", bus.out_imm, 32'd2); chk("b2b_rd1", {27'b0, bus.out_rd}, 32'd6);
      bus.in_inst = 32'h0030_0393; #1; chk("b2b_ready2", {31'b0, bus.in_ready}, 32'd1); tick();
      chk("b2b_imm2", bus.out_imm, 32'd3); chk("b2b_rd2", {27'b0, bus.out_rd}, 32'd7);
      chk("b2b_valid", {31'b0, bus.out_valid}, 32'd1);

      // write-back to a non-busy register, then read it
      bus.in_valid = 1'b0;
      bus.wb_wen   = 1'b1;
      bus.wb_waddr = 5'd9;
      bus.wb_wdata = 32'hDEAD_BEEF;
      tick();
      bus.wb_wen = 1'b0;
      chk("wb_nobusy", {31'b0, dut.busy_q[9]}, 32'd0);
      bus.in_valid = 1'b1;
      bus.in_inst  = 32'h0004_8513;   // addi x10,x9,0
      tick();
      chk("x9_read", bus.out_rdata1, 32'hDEAD_BEEF);
      chk("x9_rd",   {27'b0, bus.out_rd}, 32'd10);

      // jal x1,8 (x1 free again)
      bus.in_inst = 32'h0080_00EF;
      tick();
      chk("jal_type", {23'b0, bus.out_inst_type}, 32'h040);
      chk("jal_imm",  bus.out_imm, 32'd8);
      chk("jal_rd",   {27'b0, bus.out_rd}, 32'd1);

      // sw x0,-4(x0): negative S immediate, no destination
      bus.in_inst = 32'hFE00_2E23;
      tick();
      chk("sw_type", {23'b0, bus.out_inst_type}, 32'h080);
      chk("sw_imm",  bus.out_imm, 32'hFFFF_FFFC);
      chk("sw_rd",   {27'b0, bus.out_rd}, 32'd0);

      // illegal word
      bus.in_inst = 32'hFFFF_FFFF;
      tick();
      chk("ill_type",  {23'b0, bus.out_inst_type}, 32'h000);
      chk("ill_flag",  {31'b0, bus.illegal}, 32'd1);
      chk("ill_rd",    {27'b0, bus.out_rd}, 32'd0);
      chk("ill_busy",  {31'b0, dut.busy_q[31]}, 32'd0);

      // ebreak halts issue
      bus.in_inst = 32'h0010_0073;
      tick();
      chk("ebk_type",   {23'b0, bus.out_inst_type}, 32'h004);
      chk("ebk_halted", {31'b0, bus.halted}, 32'd1);
      bus.in_inst = 32'h0010_0593;   // addi x11,x0,1 must not issue
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("halt_ready", {31'b0, bus.in_ready}, 32'd0);
         tick();
      end
      chk("halt_drain", {31'b0, bus.out_valid}, 32'd0);
      chk("ill_sticky", {31'b0, bus.illegal}, 32'd1);

      // reset mid-operation acts without a clock edge
      bus.in_inst = 32'h0010_0073;
      rst = 1'b1;
      #1;
      chk("rst2_halted",  {31'b0, bus.halted}, 32'd0);
      chk("rst2_valid",   {31'b0, bus.out_valid}, 32'd0);
      chk("rst2_illegal", {31'b0, bus.illegal}, 32'd0);
      chk("rst2_busy",    dut.busy_q, 32'd0);
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("rst2_ready", {31'b0, bus.in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ysyx_25020047_idu.md
# ysyx_25020047_idu

Decode/issue stage that sits directly upstream of the execute unit. It takes fetched instructions from the IFU over a valid/ready handshake and owns the 32×32 architectural register file. It decodes each instruction into the execute unit's one-hot `inst_type`, immediate and operand values, and writes the decoded op into an output register for the EXU. A per-register busy scoreboard stalls on RAW/WAW hazards until the write-back port retires the pending write.

## Interface
- No parameters; `XLEN` is fixed at 32 and the register count at 32.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: IFU offers an instruction.
- `in_ready` out 1: IDU accepts this cycle.
- `in_inst` in 32: RV32I instruction word.
- `in_pc` in 32: PC of `in_inst`.
- `out_valid` out 1: decoded op is valid.
- `out_ready` in 1: EXU consumes the op.
- `out_inst_type` out 9: one-hot op code.
  - bit0 addi, bit1 jalr, bit2 ebreak, bit3 add, bit4 lui.
  - bit5 auipc, bit6 jal, bit7 sw, bit8 lw.
  - All zero means illegal.
- `out_rdata1` out 32: rs1 value.
- `out_rdata2` out 32: rs2 value.
- `out_imm` out 32: sign-extended immediate.
- `out_pc` out 32: PC of the op.
- `out_rd` out 5: destination; 0 if the op does not write.
- `wb_wen` in 1: write-back strobe.
- `wb_waddr` in 5: write-back register.
- `wb_wdata` in 32: write-back data.
- `halted` out 1: an ebreak has been issued.
- `illegal` out 1: sticky; an undecodable instruction has been issued.

## Operation
- Decode, using opcode[6:0], funct3 and funct7:
  - 0010011/000 → addi.
  - 1100111/000 → jalr.
  - 0x00100073 → ebreak.
  - 0110011/000/0000000 → add.
  - 0110111 → lui.
  - 0010111 → auipc.
  - 1101111 → jal.
  - 0100011/010 → sw.
  - 0000011/010 → lw.
  - Anything else → `inst_type` 0 and `illegal` is set.
- Immediates:
  - I-type: inst[31:20] sign-extended.
  - S-type: {inst[31:25], inst[11:7]} sign-extended.
  - U-type: {inst[31:12], 12'b0}.
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - R-type and ebreak: 0.
- Ops that write rd: addi, jalr, add, lui, auipc, jal, lw. For every other op, `out_rd` is 0.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - The write port is `wb_*`.
  - A read of register r in the same cycle as `wb_wen` && `wb_waddr`==r returns `wb_wdata` (write-through bypass).
- Scoreboard `busy[31:1]`:
  - Set on issue of an op whose `out_rd` is not 0.
  - Cleared by `wb_wen` to that register.
  - Set and clear of the same register in the same cycle: set wins.
- Hazard, evaluated combinationally on `in_inst`: the instruction's used rs1, used rs2, or rd (≠0) is busy and is not being cleared by `wb` this cycle.
- `in_ready` = !`halted` && !hazard && (!`out_valid` || `out_ready`).
- On accept, the output register loads the full decoded op and `out_valid` is set to 1.
- If `out_ready` is asserted and no accept occurs, `out_valid` is set to 0.
- While `out_valid` && !`out_ready`, the payload is held stable.
- Issuing an ebreak sets `halted`. `halted` is sticky until reset, and `in_ready` stays 0 while it is set.

## Timing
- Decode latency: 1 cycle, instruction accepted at edge N → `out_valid` at N+1.
- Throughput: 1 op/cycle with no hazards and `out_ready` held at 1.
- A RAW hazard on a register resolves in the same cycle that `wb_wen` targets that register. The instruction is accepted at that edge with the bypassed data.
- Reset values:
  - `out_valid`, `halted` and `illegal` are 0.
  - All `out_*` payload outputs are 0.
  - `busy` is all 0 and all registers are 0.
  - `in_ready` is 1 once reset deasserts.
- Reset asserted mid-operation clears all state immediately, with no clock edge needed. A pending op is dropped.
- Write-back to a register that is not busy is legal: it updates the register and leaves the scoreboard unchanged.

## Test plan
- `addi x1,x0,5` (0x00500093) → one cycle later:
  - `out_inst_type`=9'h001, `out_imm`=5, `out_rd`=1, `out_rdata1`=0.
  - `busy[1]`=1.
- `add x2,x1,x1` (0x00108133) issued with x1 busy:
  - `in_ready`=0 until `wb_wen`=1, `wb_waddr`=1, `wb_wdata`=5.
  - Accepted in that same cycle; the op shows `out_inst_type`=9'h008 and `out_rdata1`=`out_rdata2`=5.
- `lui x3,0x12345` (0x123451B7) with `out_ready`=0 for 3 cycles:
  - `out_imm`=0x12345000, `out_inst_type`=9'h010.
  - Payload held stable for those cycles; `in_ready`=0 throughout.
- Back-to-back independent addi ops with `out_ready`=1 → one issue per cycle, no bubbles.
- ebreak (0x00100073):
  - `out_inst_type`=9'h004 and `halted`=1.
  - `in_ready` stays 0 while `in_valid`=1.
  - `rst` pulse → `halted`=0 and `out_valid`=0 immediately.
- Word 0xFFFFFFFF → `out_inst_type`=0, `illegal`=1, `out_rd`=0, no busy bit set.
